// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: finds PATTERN in an accepted bit stream,
// overlapping matches allowed, with a saturating match counter.
//
// Ports:
//   clk       - system clock, all state updates on rising edge
//   rst       - synchronous reset, active-high
//   clr       - synchronous soft clear, same effect as rst
//   in_valid  - d_in is accepted on this edge when high
//   d_in      - serial data bit from the upstream flip-flop q
//   match     - one-cycle pulse, last accepted bit completed PATTERN
//   match_cnt - saturating count of matches since reset/clear
//   cnt_sat   - high while match_cnt is at its maximum
//   window    - last PATTERN_LEN accepted bits, LSB newest
//   busy      - high once at least one bit has been accepted
module serial_pattern_detector #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter int                     CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic                   d_in,
    output logic                   match,
    output logic [CNT_W-1:0]       match_cnt,
    output logic                   cnt_sat,
    output logic [PATTERN_LEN-1:0] window,
    output logic                   busy
);

    localparam int FILL_W = (PATTERN_LEN > 2) ? $clog2(PATTERN_LEN) : 1;

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PATTERN_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_NEAR  = CNT_MAX - CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    state_t              state;
    logic [FILL_W-1:0]   fill;
    logic [PATTERN_LEN-1:0] next_window;
    logic                armed;
    logic                hit;

    assign next_window = {window[PATTERN_LEN-2:0], d_in};

    // The window only holds real data once PATTERN_LEN bits have been
    // accepted; before that its reset zeros must never count as a match.
    assign armed = (state == RUN) ||
                   ((state == FILL) && (fill == FILL_LAST));

    assign hit = in_valid && armed && (next_window == PATTERN);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state     <= IDLE;
            fill      <= '0;
            window    <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            match <= 1'b0;
            if (in_valid) begin
                window <= next_window;
                busy   <= 1'b1;
                unique case (state)
                    IDLE: begin
                        state <= FILL;
                        fill  <= FILL_W'(1);
                    end
                    FILL: begin
                        if (fill == FILL_LAST) begin
                            state <= RUN;
                        end else begin
                            fill <= fill + FILL_W'(1);
                        end
                    end
                    RUN: begin
                        state <= RUN;
                    end
                    default: begin
                        state <= IDLE;
                        fill  <= '0;
                    end
                endcase
                if (hit) begin
                    match <= 1'b1;
                    // Counter sticks at its maximum; pulses keep coming.
                    if (match_cnt != CNT_MAX) begin
                        match_cnt <= match_cnt + CNT_W'(1);
                        cnt_sat   <= (match_cnt == CNT_NEAR);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed testbench for serial_pattern_detector.
// Three instances share stimulus: defaults, all-zero pattern, tiny counter.
module tb_serial_pattern_detector;

    logic clk;
    logic rst;
    logic clr;
    logic in_valid;
    logic d_in;

    logic       m_def;
    logic [7:0] c_def;
    logic       s_def;
    logic [3:0] w_def;
    logic       b_def;

    logic       m_zero;
    logic [7:0] c_zero;
    logic       s_zero;
    logic [3:0] w_zero;
    logic       b_zero;

    logic       m_sat;
    logic [1:0] c_sat;
    logic       s_sat;
    logic [3:0] w_sat;
    logic       b_sat;

    int n_checks;
    int n_fail;

    serial_pattern_detector u_def (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .d_in      (d_in),
        .match     (m_def),
        .match_cnt (c_def),
        .cnt_sat   (s_def),
        .window    (w_def),
        .busy      (b_def)
    );

    serial_pattern_detector #(
        .PATTERN (4'b0000)
    ) u_zero (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .d_in      (d_in),
        .match     (m_zero),
        .match_cnt (c_zero),
        .cnt_sat   (s_zero),
        .window    (w_zero),
        .busy      (b_zero)
    );

    serial_pattern_detector #(
        .PATTERN (4'b1111),
        .CNT_W   (2)
    ) u_sat (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .d_in      (d_in),
        .match     (m_sat),
        .match_cnt (c_sat),
        .cnt_sat   (s_sat),
        .window    (w_sat),
        .busy      (b_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, settle 1 time unit past it.
    task automatic drive(input logic r, input logic c,
                         input logic v, input logic d);
        rst      = r;
        clr      = c;
        in_valid = v;
        d_in     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({m_def, c_def, s_def, w_def, b_def} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_def: got %h expected 0",
                     {m_def, c_def, s_def, w_def, b_def});
        end
        n_checks++;
        if ({m_zero, c_zero, s_zero, w_zero, b_zero} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_zero: got %h expected 0",
                     {m_zero, c_zero, s_zero, w_zero, b_zero});
        end
        n_checks++;
        if ({m_sat, c_sat, s_sat, w_sat, b_sat} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_sat: got %h expected 0",
                     {m_sat, c_sat, s_sat, w_sat, b_sat});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_defaults();
        logic [3:0] bits;
        bits = 4'b1011;
        do_reset();
        for (int i = 3; i >= 1; i--) begin
            drive(1'b0, 1'b0, 1'b1, bits[i]);
            n_checks++;
            if (m_def !== 1'b0) begin
                n_fail++;
                $display("FAIL defaults_early bit%0d: got %b expected 0",
                         4 - i, m_def);
            end
        end
        drive(1'b0, 1'b0, 1'b1, bits[0]);
        n_checks++;
        if (m_def !== 1'b1 || c_def !== 8'd1 ||
            w_def !== 4'b1011 || b_def !== 1'b1) begin
            n_fail++;
            $display("FAIL defaults_match: got m=%b c=%0d w=%b b=%b expected m=1 c=1 w=1011 b=1",
                     m_def, c_def, w_def, b_def);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (m_def !== 1'b0 || c_def !== 8'd1) begin
            n_fail++;
            $display("FAIL defaults_pulse: got m=%b c=%0d expected m=0 c=1",
                     m_def, c_def);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits;
        logic [6:0] exp;
        bits = 7'b1011011;
        exp  = 7'b0001001;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            drive(1'b0, 1'b0, 1'b1, bits[i]);
            n_checks++;
            if (m_def !== exp[i]) begin
                n_fail++;
                $display("FAIL overlap bit%0d: got %b expected %b",
                         7 - i, m_def, exp[i]);
            end
        end
        n_checks++;
        if (c_def !== 8'd2 || w_def !== 4'b1011) begin
            n_fail++;
            $display("FAIL overlap_cnt: got c=%0d w=%b expected c=2 w=1011",
                     c_def, w_def);
        end
    endtask

    task automatic test_fill_gating();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (m_zero !== 1'b0 || b_zero !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_gate bit%0d: got m=%b b=%b expected m=0 b=1",
                         i, m_zero, b_zero);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (m_zero !== 1'b1 || c_zero !== 8'd1) begin
            n_fail++;
            $display("FAIL fill_bit4: got m=%b c=%0d expected m=1 c=1",
                     m_zero, c_zero);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (m_zero !== 1'b1 || c_zero !== 8'd2) begin
            n_fail++;
            $display("FAIL fill_bit5: got m=%b c=%0d expected m=1 c=2",
                     m_zero, c_zero);
        end
    endtask

    task automatic test_gaps_clear();
        logic [2:0] tail;
        tail = 3'b101;
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (m_def !== 1'b0 || c_def !== 8'd0 || w_def !== 4'b0010) begin
                n_fail++;
                $display("FAIL gap_hold%0d: got m=%b c=%0d w=%b expected m=0 c=0 w=0010",
                         i, m_def, c_def, w_def);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (m_def !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_bit3: got %b expected 0", m_def);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (m_def !== 1'b1 || c_def !== 8'd1 || w_def !== 4'b1011) begin
            n_fail++;
            $display("FAIL gap_match: got m=%b c=%0d w=%b expected m=1 c=1 w=1011",
                     m_def, c_def, w_def);
        end
        for (int i = 2; i >= 0; i--) begin
            drive(1'b0, 1'b0, 1'b1, tail[i]);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if ({m_def, c_def, s_def, w_def, b_def} !== 15'd0) begin
            n_fail++;
            $display("FAIL clr_state: got %h expected 0",
                     {m_def, c_def, s_def, w_def, b_def});
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (m_def !== 1'b0 || c_def !== 8'd0 ||
            w_def !== 4'b0001 || b_def !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_after: got m=%b c=%0d w=%b b=%b expected m=0 c=0 w=0001 b=1",
                     m_def, c_def, w_def, b_def);
        end
    endtask

    task automatic test_saturation();
        logic [6:0] em;
        int         ec [7];
        int         es [7];
        em = 7'b0001111;
        ec = '{0, 0, 0, 1, 2, 3, 3};
        es = '{0, 0, 0, 0, 0, 1, 1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            n_checks++;
            if (m_sat !== em[6-i] || c_sat !== 2'(ec[i]) ||
                s_sat !== 1'(es[i])) begin
                n_fail++;
                $display("FAIL sat bit%0d: got m=%b c=%0d s=%b expected m=%b c=%0d s=%0d",
                         i + 1, m_sat, c_sat, s_sat, em[6-i], ec[i], es[i]);
            end
        end
    endtask

    task automatic test_reset_priority();
        logic [3:0] bits;
        bits = 4'b1011;
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if ({m_def, c_def, s_def, w_def, b_def} !== 15'd0) begin
            n_fail++;
            $display("FAIL rst_prio: got %h expected 0",
                     {m_def, c_def, s_def, w_def, b_def});
        end
        for (int i = 3; i >= 0; i--) begin
            drive(1'b0, 1'b0, 1'b1, bits[i]);
            n_checks++;
            if (m_def !== (i == 0)) begin
                n_fail++;
                $display("FAIL rst_fresh bit%0d: got %b expected %b",
                         4 - i, m_def, (i == 0));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b0;
        d_in     = 1'b0;
        test_reset();
        test_defaults();
        test_overlap();
        test_fill_gating();
        test_gaps_clear();
        test_saturation();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
